// File: rtl/frame_capture_sequencer.sv
// Purpose: sequences frame-store captures (trigger -> wait capture_done -> gated word readout -> holdoff/re-arm).
// Ports:   axi_clk/axi_reset (sync, active-high), start/abort/num_frames/interval from the register bank,
//          capture_done/host_rdStrobe in, trigger/frame_read_rdStrobe to the store, busy/status to software.
module frame_capture_sequencer #(
  parameter int FRAME_WIDTH     = 234,
  parameter int WORD_WIDTH      = 32,
  parameter int CAPTURE_TIMEOUT = 1024
) (
  input  logic        axi_clk,
  input  logic        axi_reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] num_frames,
  input  logic [23:0] interval,
  input  logic        capture_done,
  input  logic        host_rdStrobe,
  output logic        trigger,
  output logic        frame_read_rdStrobe,
  output logic        busy,
  output logic [31:0] status
);

  localparam int WORDS_PER_FRAME = (FRAME_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int TO_W            = $clog2(CAPTURE_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_TRIG     = 3'd1;
  localparam logic [2:0] S_WAIT_CAP = 3'd2;
  localparam logic [2:0] S_READOUT  = 3'd3;
  localparam logic [2:0] S_HOLDOFF  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic [7:0]      word_index_q, word_index_d;
  logic [23:0]     interval_cnt_q, interval_cnt_d;
  logic [TO_W-1:0] timeout_cnt_q, timeout_cnt_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic            aborted_q, aborted_d;
  logic            stray_q, stray_d;

  // Strobes are only passed to the store while a frame is being read out;
  // an abort cycle neither forwards nor counts a strobe.
  assign frame_read_rdStrobe = (state_q == S_READOUT) && host_rdStrobe && !abort;
  assign trigger             = (state_q == S_TRIG) && !abort;
  assign busy                = (state_q != S_IDLE);
  assign status = {frame_count_q, word_index_q, state_q, stray_q, aborted_q, timeout_q, done_q, busy};

  always_comb begin
    state_d        = state_q;
    frame_count_d  = frame_count_q;
    word_index_d   = word_index_q;
    timeout_cnt_d  = timeout_cnt_q;
    done_d         = done_q;
    timeout_d      = timeout_q;
    aborted_d      = aborted_q;
    stray_d        = stray_q;

    // Free-running, saturating; zeroed on entry to TRIG so it reads 0 during
    // the trigger cycle and N exactly N cycles later.
    interval_cnt_d = (interval_cnt_q == 24'hFF_FFFF) ? interval_cnt_q : interval_cnt_q + 24'd1;

    if (host_rdStrobe && !frame_read_rdStrobe) begin
      stray_d = 1'b1;
    end

    if (abort) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d        = S_TRIG;
            done_d         = 1'b0;
            timeout_d      = 1'b0;
            aborted_d      = 1'b0;
            stray_d        = 1'b0;
            frame_count_d  = 16'd0;
            word_index_d   = 8'd0;
            interval_cnt_d = 24'd0;
          end
        end
        S_TRIG: begin
          timeout_cnt_d = '0;
          state_d       = S_WAIT_CAP;
        end
        S_WAIT_CAP: begin
          if (capture_done) begin
            state_d = S_READOUT;
          end else if (timeout_cnt_q == TO_W'(CAPTURE_TIMEOUT - 1)) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
          end else begin
            timeout_cnt_d = timeout_cnt_q + TO_W'(1);
          end
        end
        S_READOUT: begin
          if (host_rdStrobe) begin
            if (word_index_q == 8'(WORDS_PER_FRAME - 1)) begin
              word_index_d  = 8'd0;
              frame_count_d = frame_count_q + 16'd1;
              if ((num_frames != 16'd0) && (frame_count_q + 16'd1 == num_frames)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = S_HOLDOFF;
              end
            end else begin
              word_index_d = word_index_q + 8'd1;
            end
          end
        end
        S_HOLDOFF: begin
          // cnt >= interval-1, done in 25 bits so interval 0 acts like 1.
          if ({1'b0, interval_cnt_q} + 25'd1 >= {1'b0, interval}) begin
            state_d        = S_TRIG;
            interval_cnt_d = 24'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q        <= S_IDLE;
      frame_count_q  <= 16'd0;
      word_index_q   <= 8'd0;
      interval_cnt_q <= 24'd0;
      timeout_cnt_q  <= '0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      aborted_q      <= 1'b0;
      stray_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_count_q  <= frame_count_d;
      word_index_q   <= word_index_d;
      interval_cnt_q <= interval_cnt_d;
      timeout_cnt_q  <= timeout_cnt_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
      aborted_q      <= aborted_d;
      stray_q        <= stray_d;
    end
  end

endmodule

// File: tb/tb_frame_capture_sequencer.sv
// Purpose: exercises frame_capture_sequencer as host and frame store, predicting trigger times,
//          forwarded word counts and status flags from the sequencing rules.
// Ports:   none (top-level bench).
module tb_frame_capture_sequencer;

  logic        axi_clk = 1'b0;
  logic        axi_reset, start, abort, capture_done, host_rdStrobe;
  logic [15:0] num_frames;
  logic [23:0] interval;
  logic        trigger, frame_read_rdStrobe, busy;
  logic [31:0] status;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, trig_cnt = 0, fwd_cnt = 0;
  int exp_trig = 0, last_strobe_cyc = 0;

  frame_capture_sequencer dut (
    .axi_clk             (axi_clk),
    .axi_reset           (axi_reset),
    .start               (start),
    .abort               (abort),
    .num_frames          (num_frames),
    .interval            (interval),
    .capture_done        (capture_done),
    .host_rdStrobe       (host_rdStrobe),
    .trigger             (trigger),
    .frame_read_rdStrobe (frame_read_rdStrobe),
    .busy                (busy),
    .status              (status)
  );

  initial forever #5 axi_clk = ~axi_clk;

  always @(posedge axi_clk) cyc <= cyc + 1;

  always @(negedge axi_clk) begin
    if (trigger === 1'b1) trig_cnt <= trig_cnt + 1;
    if (frame_read_rdStrobe === 1'b1) fwd_cnt <= fwd_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion, required completion before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int nf, input int iv);
    num_frames = 16'(nf);
    interval   = 24'(iv);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    exp_trig   = cyc;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_trigger", 32'(trigger), 32'd1);
  endtask

  task automatic wait_trigger();
    int got = 0;
    for (int b = 0; b < 3000; b++) begin
      if (trigger === 1'b1) begin
        got = 1;
        break;
      end
      tick();
    end
    chk("trigger_seen", 32'(got), 32'd1);
    chk("trigger_cycle", 32'(cyc), 32'(exp_trig));
  endtask

  // Act as the store: hold capture_done low a few cycles (optionally poking
  // start meanwhile, which must be ignored), then report a captured frame.
  task automatic enter_readout(input bit poke_start);
    tick();
    start = poke_start;
    repeat (2 + $urandom_range(0, 5)) tick();
    start = 1'b0;
    capture_done = 1'b1;
    tick();
  endtask

  task automatic strobe();
    host_rdStrobe = 1'b1;
    #1;
    chk("fwd_strobe", 32'(frame_read_rdStrobe), 32'd1);
    last_strobe_cyc = cyc;
    tick();
    host_rdStrobe = 1'b0;
  endtask

  task automatic run_frames(input int nf, input int iv, input int n, input bit poke_start);
    int f0, nxt;
    for (int f = 0; f < n; f++) begin
      wait_trigger();
      enter_readout(poke_start);
      f0 = fwd_cnt;
      for (int w = 0; w < 8; w++) begin
        repeat ($urandom_range(0, 3)) tick();
        strobe();
      end
      capture_done = 1'b0;
      chk("fwd_per_frame", 32'(fwd_cnt - f0), 32'd8);
      chk("frame_count", 32'(status[31:16]), 32'(f + 1));
      chk("word_index_wrap", 32'(status[15:8]), 32'd0);
      if (nf != 0 && f + 1 == nf) begin
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_flag", 32'(status[1]), 32'd1);
      end else begin
        chk("holdoff_busy", 32'(busy), 32'd1);
        nxt = exp_trig + ((iv < 1) ? 1 : iv);
        if (last_strobe_cyc + 2 > nxt) nxt = last_strobe_cyc + 2;
        exp_trig = nxt;
      end
    end
  endtask

  initial begin
    int tc0, fc0, t0, nf, iv, got;
    axi_reset = 1'b1; start = 1'b0; abort = 1'b0; capture_done = 1'b0;
    host_rdStrobe = 1'b0; num_frames = 16'd0; interval = 24'd0;
    tick();
    tick();
    chk("reset_status", status, 32'd0);
    chk("reset_trigger", 32'(trigger), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_fwd", 32'(frame_read_rdStrobe), 32'd0);
    axi_reset = 1'b0;
    tick();

    // Stray read while idle.
    host_rdStrobe = 1'b1;
    #1;
    chk("stray_not_fwd", 32'(frame_read_rdStrobe), 32'd0);
    tick();
    host_rdStrobe = 1'b0;
    chk("stray_flag", 32'(status[4]), 32'd1);

    // Single shot; start clears the stray flag.
    tc0 = trig_cnt; fc0 = fwd_cnt;
    do_start(1, 0);
    chk("start_clears_stray", 32'(status[4]), 32'd0);
    run_frames(1, 0, 1, 1'b0);
    repeat (5) tick();
    chk("single_trig_total", 32'(trig_cnt - tc0), 32'd1);
    chk("single_fwd_total", 32'(fwd_cnt - fc0), 32'd8);

    // Start held during WAIT_CAP must not produce another trigger.
    tc0 = trig_cnt;
    do_start(1, 0);
    run_frames(1, 0, 1, 1'b1);
    repeat (5) tick();
    chk("ignored_start_trig_total", 32'(trig_cnt - tc0), 32'd1);

    // Three frames, interval-limited spacing.
    tc0 = trig_cnt;
    do_start(3, 100);
    run_frames(3, 100, 3, 1'b0);
    repeat (5) tick();
    chk("multi_trig_total", 32'(trig_cnt - tc0), 32'd3);

    // Randomized sequences covering both interval- and readout-limited spacing.
    for (int s = 0; s < 4; s++) begin
      nf = $urandom_range(1, 4);
      iv = $urandom_range(0, 40);
      tc0 = trig_cnt;
      do_start(nf, iv);
      run_frames(nf, iv, nf, 1'($urandom_range(0, 1)));
      repeat (3) tick();
      chk("rand_trig_total", 32'(trig_cnt - tc0), 32'(nf));
    end

    // Capture timeout.
    fc0 = fwd_cnt;
    do_start(1, 0);
    t0 = exp_trig;
    got = 0;
    for (int b = 0; b < 1100; b++) begin
      if (busy === 1'b0) begin
        got = 1;
        break;
      end
      tick();
    end
    chk("timeout_reached", 32'(got), 32'd1);
    chk("timeout_cycle", 32'(cyc), 32'(t0 + 1025));
    chk("timeout_flag", 32'(status[2]), 32'd1);
    chk("timeout_no_fwd", 32'(fwd_cnt - fc0), 32'd0);

    // Abort after four of eight words.
    do_start(1, 0);
    wait_trigger();
    enter_readout(1'b0);
    for (int w = 0; w < 4; w++) strobe();
    abort = 1'b1;
    #1;
    chk("abort_trigger_low", 32'(trigger), 32'd0);
    tick();
    abort = 1'b0;
    capture_done = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_flag", 32'(status[3]), 32'd1);
    chk("abort_word_index", 32'(status[15:8]), 32'd4);
    chk("abort_frame_count", 32'(status[31:16]), 32'd0);
    host_rdStrobe = 1'b1;
    #1;
    chk("post_abort_not_fwd", 32'(frame_read_rdStrobe), 32'd0);
    tick();
    host_rdStrobe = 1'b0;
    chk("post_abort_stray", 32'(status[4]), 32'd1);

    // Continuous mode, then reset in the middle of a readout.
    do_start(0, 50);
    run_frames(0, 50, 5, 1'b0);
    wait_trigger();
    enter_readout(1'b0);
    for (int w = 0; w < 3; w++) strobe();
    axi_reset = 1'b1;
    host_rdStrobe = 1'b1;
    tick();
    chk("midreset_status", status, 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_trigger", 32'(trigger), 32'd0);
    chk("midreset_fwd", 32'(frame_read_rdStrobe), 32'd0);
    axi_reset = 1'b0;
    host_rdStrobe = 1'b0;
    capture_done = 1'b0;
    tc0 = trig_cnt;
    repeat (60) tick();
    chk("midreset_no_trigger", 32'(trig_cnt - tc0), 32'd0);
    do_start(1, 0);
    chk("restart_frame_count", 32'(status[31:16]), 32'd0);
    run_frames(1, 0, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
